// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular buffer between fetch and decode.
// Optional macro IF_ID_QUEUE_NOP_FILL_EN drives a NOP bubble (out_pc=0, out_ins=NOP_INS) when empty.
module if_id_queue #(
    parameter int                PC_W    = 32,
    parameter int                INS_W   = 32,
    parameter int                PC_INC  = 4,
    parameter int                DEPTH   = 2,
    parameter logic [INS_W-1:0]  NOP_INS = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PC_W-1:0]               in_pc,
    input  logic [INS_W-1:0]              in_ins,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_W-1:0]               out_pc,
    output logic [INS_W-1:0]              out_ins,
    output logic [$clog2(DEPTH+1)-1:0]    out_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W+INS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic [PC_W+INS_W-1:0] head;

    // Exact modulo-DEPTH wrap so non-power-of-2 depths use every slot.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake: a transfer happens on a side only in a cycle where both valid and
    // ready are high at the rising edge; in_ready may depend on out_ready because a
    // same-cycle pop frees a slot, letting a full queue accept at full rate.
    always_comb begin
        out_valid = (count != '0);
        pop       = out_valid & out_ready;
        in_ready  = (count < CNT_W'(DEPTH)) | pop;
        push      = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push)
            mem[wr_ptr] <= {in_pc + PC_W'(PC_INC), in_ins};
    end

    assign head      = mem[rd_ptr];
    assign out_count = count;

`ifdef IF_ID_QUEUE_NOP_FILL_EN
    assign out_pc  = out_valid ? head[PC_W+INS_W-1:INS_W] : '0;
    assign out_ins = out_valid ? head[INS_W-1:0] : NOP_INS;
`else
    assign out_pc  = head[PC_W+INS_W-1:INS_W];
    assign out_ins = head[INS_W-1:0];
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=2 (index 0) and DEPTH=3 (index 1) instances checked
// against an in-order list model of the queue contents.
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_pc     [2];
    logic [31:0] in_ins    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_pc    [2];
    logic [31:0] out_ins   [2];
    logic [1:0]  out_count [2];

    int checks = 0;
    int errors = 0;

    // Model: list of pending {pc+4, ins} in arrival order, head at index 0.
    logic [63:0] mbuf [2][16];
    int          mcnt [2];

    if_id_queue #(.DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pc(in_pc[0]), .in_ins(in_ins[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pc(out_pc[0]),
        .out_ins(out_ins[0]), .out_count(out_count[0])
    );

    if_id_queue #(.DEPTH(3)) dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pc(in_pc[1]), .in_ins(in_ins[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pc(out_pc[1]),
        .out_ins(out_ins[1]), .out_count(out_count[1])
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mdepth(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic drive(input int d, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid[d]  = v;
        in_pc[d]     = pc;
        in_ins[d]    = ins;
        out_ready[d] = ordy;
        flush[d]     = fl;
    endtask

    // Advance one clock edge and apply the queue rules to the model.
    task automatic tick();
        bit          push [2];
        bit          pop  [2];
        logic [63:0] ent  [2];
        for (int d = 0; d < 2; d++) begin
            pop[d]  = (mcnt[d] != 0) && out_ready[d];
            push[d] = in_valid[d] && ((mcnt[d] < mdepth(d)) || pop[d]);
            ent[d]  = {in_pc[d] + 32'd4, in_ins[d]};
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst || flush[d]) begin
                mcnt[d] = 0;
            end else begin
                if (pop[d]) begin
                    for (int i = 0; i < 15; i++) mbuf[d][i] = mbuf[d][i+1];
                    mcnt[d]--;
                end
                if (push[d]) begin
                    mbuf[d][mcnt[d]] = ent[d];
                    mcnt[d]++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #4;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]);
            end
            checks++;
            if (out_count[d] !== 2'd0) begin
                errors++; $display("FAIL reset_out_count[%0d]: got %0d want 0", d, out_count[d]);
            end
            checks++;
            if (in_ready[d] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]);
            end
`ifdef IF_ID_QUEUE_NOP_FILL_EN
            checks++;
            if (out_ins[d] !== 32'h0 || out_pc[d] !== 32'h0) begin
                errors++; $display("FAIL reset_nop[%0d]: got pc=%h ins=%h want 0/0", d, out_pc[d], out_ins[d]);
            end
`endif
        end
        tick();
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'(4 * k), 32'hA + 32'(k), 1, 0);
            #4;
            checks++;
            if (in_ready[0] !== 1'b1) begin
                errors++; $display("FAIL stream_in_ready k=%0d: got %b want 1", k, in_ready[0]);
            end
            if (k > 0) begin
                checks++;
                if (out_valid[0] !== 1'b1 || out_pc[0] !== 32'(4 * k) ||
                    out_ins[0] !== 32'hA + 32'(k - 1) || out_count[0] !== 2'd1) begin
                    errors++;
                    $display("FAIL stream_out k=%0d: got v=%b pc=%h ins=%h cnt=%0d want 1/%h/%h/1",
                             k, out_valid[0], out_pc[0], out_ins[0], out_count[0], 4 * k, 32'hA + 32'(k - 1));
                end
            end
            tick();
        end
        drive(0, 0, 0, 0, 1, 0);
        #4;
        checks++;
        if (out_pc[0] !== 32'hC || out_ins[0] !== 32'hC || out_count[0] !== 2'd1) begin
            errors++; $display("FAIL stream_last: got pc=%h ins=%h cnt=%0d want c/c/1", out_pc[0], out_ins[0], out_count[0]);
        end
        tick();
        #4;
        checks++;
        if (out_valid[0] !== 1'b0 || out_count[0] !== 2'd0) begin
            errors++; $display("FAIL stream_drain: got v=%b cnt=%0d want 0/0", out_valid[0], out_count[0]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        drive(0, 1, 32'h100, 32'hA, 0, 0); tick();
        drive(0, 1, 32'h104, 32'hB, 0, 0); tick();
        drive(0, 1, 32'h108, 32'hC, 0, 0);
        #4;
        checks++;
        if (out_count[0] !== 2'd2 || in_ready[0] !== 1'b0) begin
            errors++; $display("FAIL bp_full: got cnt=%0d rdy=%b want 2/0", out_count[0], in_ready[0]);
        end
        tick();
        drive(0, 1, 32'h108, 32'hC, 1, 0);
        #4;
        checks++;
        if (in_ready[0] !== 1'b1 || out_ins[0] !== 32'hA || out_pc[0] !== 32'h104) begin
            errors++; $display("FAIL bp_pop_push: got rdy=%b ins=%h pc=%h want 1/a/104", in_ready[0], out_ins[0], out_pc[0]);
        end
        tick();
        drive(0, 0, 0, 0, 1, 0);
        #4;
        checks++;
        if (out_count[0] !== 2'd2 || out_ins[0] !== 32'hB) begin
            errors++; $display("FAIL bp_second: got cnt=%0d ins=%h want 2/b", out_count[0], out_ins[0]);
        end
        tick();
        #4;
        checks++;
        if (out_count[0] !== 2'd1 || out_ins[0] !== 32'hC || out_pc[0] !== 32'h10C) begin
            errors++; $display("FAIL bp_third: got cnt=%0d ins=%h pc=%h want 1/c/10c", out_count[0], out_ins[0], out_pc[0]);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_flush();
        drive(0, 1, 32'h200, 32'hD, 0, 0); tick();
        drive(0, 1, 32'h204, 32'hE, 0, 0); tick();
        drive(0, 1, 32'h208, 32'hF, 1, 1);
        #4;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready[0]);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (out_valid[0] !== 1'b0 || out_count[0] !== 2'd0) begin
            errors++; $display("FAIL flush_empty: got v=%b cnt=%0d want 0/0", out_valid[0], out_count[0]);
        end
        tick();
        drive(0, 1, 32'h300, 32'h77, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        checks++;
        if (out_valid[0] !== 1'b1 || out_ins[0] !== 32'h77 || out_count[0] !== 2'd1) begin
            errors++; $display("FAIL flush_refill: got v=%b ins=%h cnt=%0d want 1/77/1", out_valid[0], out_ins[0], out_count[0]);
        end
        drive(0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_pc_wrap();
        drive(0, 1, 32'hFFFF_FFFC, 32'h5, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        #4;
        checks++;
        if (out_pc[0] !== 32'h0 || out_ins[0] !== 32'h5) begin
            errors++; $display("FAIL pc_wrap: got pc=%h ins=%h want 0/5", out_pc[0], out_ins[0]);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random_depth3();
        int id = 1;
        for (int n = 0; n < 300; n++) begin
            rst = (n == 150);
            drive(1, ($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  32'(id), ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
            #4;
            checks++;
            if (out_valid[1] !== (mcnt[1] != 0) || out_count[1] !== 2'(mcnt[1]) ||
                in_ready[1] !== ((mcnt[1] < 3) || ((mcnt[1] != 0) && out_ready[1]))) begin
                errors++;
                $display("FAIL rand_ctrl n=%0d: got v=%b cnt=%0d rdy=%b want cnt=%0d",
                         n, out_valid[1], out_count[1], in_ready[1], mcnt[1]);
            end
            if (mcnt[1] != 0) begin
                checks++;
                if ({out_pc[1], out_ins[1]} !== mbuf[1][0]) begin
                    errors++;
                    $display("FAIL rand_data n=%0d: got pc=%h ins=%h want pc=%h ins=%h",
                             n, out_pc[1], out_ins[1], mbuf[1][0][63:32], mbuf[1][0][31:0]);
                end
            end
            if (in_valid[1] && in_ready[1]) id++;
            tick();
            if (n == 150) begin
                checks++;
                if (out_count[1] !== 2'd0 || out_valid[1] !== 1'b0) begin
                    errors++; $display("FAIL rand_mid_reset: got cnt=%0d v=%b want 0/0", out_count[1], out_valid[1]);
                end
            end
        end
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        mcnt[0] = 0;
        mcnt[1] = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_pc_wrap();
        test_random_depth3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Sits between the fetch stage and the decode stage.
- Holds up to DEPTH fetched instruction/PC pairs in a circular buffer with a valid/ready handshake on each side and a synchronous flush.
- Decode can stall without losing fetched instructions; fetch can run ahead by DEPTH entries.

Parameters:
PC_W, 32, width of program counter
INS_W, 32, width of instruction word
PC_INC, 4, constant added to PC on enqueue (out_pc = in_pc + PC_INC)
DEPTH, 2, number of buffer entries; legal range 1..16, non-power-of-2 allowed
NOP_INS, 0, instruction value driven when no valid entry (used only with optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all entries (branch/jump redirect)
in_valid  in  1  fetch presents a valid pc/ins pair
in_ready  out  1  queue accepts the pair this cycle
in_pc  in  PC_W  PC of fetched instruction
in_ins  in  INS_W  fetched instruction
out_valid  out  1  head entry is valid
out_ready  in  1  decode consumes head this cycle
out_pc  out  PC_W  head PC + PC_INC
out_ins  out  INS_W  head instruction
out_count  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (rst=1 at clock edge): count=0, rd_ptr=0, wr_ptr=0, out_valid=0, out_count=0. Storage contents don't care; out_pc/out_ins undefined without the optional feature.
- Priority at each edge: rst > flush > push/pop.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- out_valid = (count != 0); combinational from registered count.
- in_ready = (count < DEPTH) | pop. A pop frees a slot in the same cycle, so push+pop at full is legal.
- Push: store {in_pc + PC_INC, in_ins} at wr_ptr. Addition is modulo 2^PC_W (carry discarded). Advance wr_ptr.
- Pop: advance rd_ptr.
- Pointer wrap: DEPTH-1 -> 0, exact for any DEPTH; no power-of-2 masking.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Latency: a pair pushed at edge N appears on out_* after edge N (one cycle). No bypass from in_* to out_*.
- out_pc/out_ins are read combinationally from the entry at rd_ptr.
- Full-rate operation: with out_ready held high and in_valid high, one pair per cycle for any DEPTH>=1.
- Flush (flush=1, rst=0):
  - count=0, rd_ptr=wr_ptr=0, out_valid=0 on the next cycle.
  - A same-cycle push is discarded; a same-cycle pop is ignored.
  - in_ready still follows the formula in the flush cycle. Fetch may see a handshake, but the data is dropped.
- Reset or flush mid-stream: all queued entries are lost; no partial state survives.
- out_count is always equal to count.
- Invariants: count never exceeds DEPTH and never underflows. Pop with count=0 is impossible because out_valid=0.

Optional Feature:
- Macro: IF_ID_QUEUE_NOP_FILL_EN.
- Defined:
  - When out_valid=0 (including after reset and flush), out_ins=NOP_INS and out_pc=0. Decode always sees a defined bubble.
  - When out_valid=1, outputs show the head entry as normal.
- Not defined:
  - out_pc/out_ins always show the storage at rd_ptr, regardless of out_valid.
  - Value is stale or undefined when empty; consumers must qualify with out_valid.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> out_valid=0, out_count=0, in_ready=1; with NOP_FILL_EN, out_ins=0, out_pc=0.
- Streaming, DEPTH=2, out_ready=1: push pc=0x00, 0x04, 0x08 with ins=0xA,0xB,0xC on consecutive cycles -> out_pc 0x04, 0x08, 0x0C and ins A,B,C one cycle after each push; out_count stays 1; no backpressure.
- Backpressure, DEPTH=2, out_ready=0: push 3 pairs -> first two accepted, out_count=2, in_ready=0 on the third. Raise out_ready -> head pops, third accepted in the same cycle, count stays 2, order A,B,C preserved.
- Flush: fill to 2, then flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, the flushed-cycle pair never appears on the output.
- PC wrap, PC_W=32: push in_pc=0xFFFFFFFC -> out_pc=0x00000000.
- Non-power-of-2, DEPTH=3: push and pop 7 entries with random out_ready -> pointers wrap 2->0, output order matches input, count never exceeds 3; rst asserted mid-stream returns count to 0 on the next cycle.
